// File: rtl/sub_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the bit-serial subtractor slice.
//   state_t       : controller states (IDLE, RUN, DONE)
//   SUB_WIDTH_DEF : default operand width used when no WIDTH is given
// ---------------------------------------------------------------------------
package sub_pkg;

    // Encodings are fixed so that older code decoding the raw 2-bit state
    // still agrees with this package.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int SUB_WIDTH_DEF = 4;

endpackage

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor cell built from gate primitives, the arithmetic
// twin of the full_adder cell.
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   diff : a ^ b ^ bin
//   bout : borrow out, (~a & b) | (~a & bin) | (b & bin)
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic aXorB;
    logic aNot;
    logic borrowAB;
    logic borrowAIn;
    logic borrowBIn;

    // Difference bit is the three-way parity of the inputs.
    xor gDiff0 (aXorB, a, b);
    xor gDiff1 (diff, aXorB, bin);

    // A borrow is needed whenever the subtracted amount (b + bin) exceeds a.
    not gNotA  (aNot, a);
    and gBor0  (borrowAB, aNot, b);
    and gBor1  (borrowAIn, aNot, bin);
    and gBor2  (borrowBIn, b, bin);
    or  gBorOr (bout, borrowAB, borrowAIn, borrowBIn);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial ripple-borrow subtractor: computes A - B - Bin, LSB first, one
// bit per clock using a single full_subtractor cell and a registered borrow.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : request a subtraction (only looked at in IDLE)
//   A, B  : operands, captured on the accepted start edge
//   Bin   : borrow in, captured on the accepted start edge
//   busy  : high in RUN and DONE
//   done  : one-cycle pulse when Diff/Bout carry a fresh result
//   Diff  : (A - B - Bin) mod 2^WIDTH
//   Bout  : 1 when A < B + Bin (unsigned)
// ---------------------------------------------------------------------------
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] aShift_q, aShift_d;
    logic [WIDTH-1:0] bShift_q, bShift_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;

    logic             cellDiff;
    logic             cellBout;

    // The single arithmetic cell always works on the operand LSBs and the
    // borrow carried over from the previous bit.
    full_subtractor uCell (
        .a    (aShift_q[0]),
        .b    (bShift_q[0]),
        .bin  (borrow_q),
        .diff (cellDiff),
        .bout (cellBout)
    );

    // Next-state logic. In IDLE an accepted start loads the operands and the
    // incoming borrow. In RUN each cycle consumes one bit: the new difference
    // bit enters the result at the MSB so that after WIDTH shifts bit 0 sits
    // at the LSB. The visible Diff/Bout are only written on the last bit, so
    // partial results never appear on the outputs.
    always_comb begin
        state_d  = state_q;
        aShift_d = aShift_q;
        bShift_d = bShift_q;
        result_d = result_q;
        borrow_d = borrow_q;
        count_d  = count_q;
        diff_d   = diff_q;
        bout_d   = bout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    aShift_d = A;
                    bShift_d = B;
                    borrow_d = Bin;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d = {cellDiff, result_q[WIDTH-1:1]};
                aShift_d = aShift_q >> 1;
                bShift_d = bShift_q >> 1;
                borrow_d = cellBout;
                count_d  = count_q + CW'(1);
                if (count_q == LAST) begin
                    diff_d  = {cellDiff, result_q[WIDTH-1:1]};
                    bout_d  = cellBout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    // and clears the visible result as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            aShift_q <= '0;
            bShift_q <= '0;
            result_q <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            aShift_q <= aShift_d;
            bShift_q <= bShift_d;
            result_q <= result_d;
            borrow_q <= borrow_d;
            count_q  <= count_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    // Handshake outputs are pure decodes of the state register, so nothing
    // on the input side reaches them combinationally.
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor. A WIDTH=4 instance covers the
// handshake, latency, start-while-busy, reset and back-to-back behaviour; a
// WIDTH=8 instance sweeps boundary operand combinations with start held high.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk;
    logic       rst;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       bin4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       bout4;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bout8;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] expDiff;
        logic       expBout;
    } vec_t;

    vec_t vecs[7];

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .A     (a4),
        .B     (b4),
        .Bin   (bin4),
        .busy  (busy4),
        .done  (done4),
        .Diff  (diff4),
        .Bout  (bout4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .Bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .Diff  (diff8),
        .Bout  (bout8)
    );

    // Free-running 10-unit clock shared by both instances.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against the bench's own expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Starting from the sample just after the start edge, wait for done and
    // report how many further edges it took and how many samples saw busy.
    task automatic waitDone4(output int lat, output int busyCnt, output bit seen);
        lat     = 0;
        busyCnt = 0;
        seen    = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (busy4) busyCnt++;
            if (done4) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("done4_seen", 32'(seen), 32'd1);
    endtask

    // Pulse start for one cycle with the given operands, then check latency,
    // busy duration and the result on the WIDTH=4 instance.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic bin, input logic [3:0] expDiff,
                                 input logic expBout);
        int lat;
        int busyCnt;
        bit seen;
        @(posedge clk);
        #1;
        a4     = a;
        b4     = b;
        bin4   = bin;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        a4     = ~a;
        b4     = ~b;
        bin4   = ~bin;
        waitDone4(lat, busyCnt, seen);
        checkOutput("latency4", 32'(lat), 32'd4);
        checkOutput("busyCycles4", 32'(busyCnt), 32'd5);
        checkOutput("diff4", 32'(diff4), 32'(expDiff));
        checkOutput("bout4", 32'(bout4), 32'(expBout));
    endtask

    initial begin
        int lat;
        int busyCnt;
        bit seen;
        int doneCount;
        int k;
        int lastDone;
        int expSeq[3];
        int nextA[3];
        int vals[12];
        int va;
        int vb;
        int vbin;
        int expD;
        int expB;

        checks = 0;
        errors = 0;

        vecs[0] = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0};
        vecs[1] = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1};
        vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
        vecs[3] = '{4'h7, 4'h7, 1'b0, 4'h0, 1'b0};
        vecs[4] = '{4'hF, 4'h0, 1'b1, 4'hE, 1'b0};
        vecs[5] = '{4'h0, 4'hF, 1'b0, 4'h1, 1'b1};
        vecs[6] = '{4'h8, 4'h8, 1'b1, 4'hF, 1'b1};

        rst    = 1'b1;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        bin4   = 1'b0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        bin8   = 1'b0;

        // Reset state of both instances.
        #12;
        checkOutput("rst_busy4", 32'(busy4), 32'd0);
        checkOutput("rst_done4", 32'(done4), 32'd0);
        checkOutput("rst_diff4", 32'(diff4), 32'd0);
        checkOutput("rst_bout4", 32'(bout4), 32'd0);
        checkOutput("rst_busy8", 32'(busy8), 32'd0);
        checkOutput("rst_diff8", 32'(diff8), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven single operations.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin,
                          vecs[i].expDiff, vecs[i].expBout);
        end

        // Start re-asserted with different operands during the second RUN
        // cycle must be ignored: one done, result of the first operation.
        @(posedge clk);
        #1;
        a4 = 4'h5; b4 = 4'h2; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        @(posedge clk);
        #1;
        a4 = 4'hF; b4 = 4'hF; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        waitDone4(lat, busyCnt, seen);
        checkOutput("ignore_latency", 32'(lat), 32'd2);
        checkOutput("ignore_diff", 32'(diff4), 32'd3);
        checkOutput("ignore_bout", 32'(bout4), 32'd0);
        doneCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done4) doneCount++;
        end
        checkOutput("ignore_extra_done", 32'(doneCount), 32'd0);

        // Asynchronous reset in the third RUN cycle clears everything at once
        // and the abandoned operation never reports done.
        @(posedge clk);
        #1;
        a4 = 4'h9; b4 = 4'h3; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy4), 32'd0);
        checkOutput("midrst_done", 32'(done4), 32'd0);
        checkOutput("midrst_diff", 32'(diff4), 32'd0);
        checkOutput("midrst_bout", 32'(bout4), 32'd0);
        #1;
        rst = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done4 || busy4) doneCount++;
        end
        checkOutput("midrst_no_done", 32'(doneCount), 32'd0);
        applyStimulus(4'hC, 4'h4, 1'b0, 4'h8, 1'b0);

        // Start held high: three operations, done every WIDTH+2 cycles, Diff
        // holding the previous result between pulses.
        expSeq[0] = 5;  expSeq[1] = 9;  expSeq[2] = 2;
        nextA[0]  = 6;  nextA[1]  = 10; nextA[2]  = 3;
        @(posedge clk);
        #1;
        a4 = 4'(nextA[0]); b4 = 4'h1; bin4 = 1'b0; start4 = 1'b1;
        k = 0;
        lastDone = 0;
        for (int cyc = 0; cyc < 60 && k < 3; cyc++) begin
            @(posedge clk);
            #1;
            if (done4) begin
                checkOutput("cont_diff", 32'(diff4), 32'(expSeq[k]));
                checkOutput("cont_bout", 32'(bout4), 32'd0);
                if (k > 0) checkOutput("cont_spacing", 32'(cyc - lastDone), 32'd6);
                lastDone = cyc;
                k++;
                if (k < 3) a4 = 4'(nextA[k]);
            end else if (k > 0) begin
                checkOutput("cont_hold", 32'(diff4), 32'(expSeq[k-1]));
            end
        end
        start4 = 1'b0;
        checkOutput("cont_count", 32'(k), 32'd3);

        // WIDTH=8 sweep over boundary operands with start held high.
        vals = '{0, 1, 2, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0};
        k = 0;
        va = vals[0]; vb = vals[0]; vbin = 0;
        @(posedge clk);
        #1;
        a8 = 8'(va); b8 = 8'(vb); bin8 = 1'b0; start8 = 1'b1;
        lastDone = 0;
        for (int cyc = 0; cyc < 4000 && k < 288; cyc++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                expD = (va - vb - vbin) & 255;
                expB = (va < vb + vbin) ? 1 : 0;
                checkOutput("sweep_diff8", 32'(diff8), 32'(expD));
                checkOutput("sweep_bout8", 32'(bout8), 32'(expB));
                if (k > 0) checkOutput("sweep_spacing8", 32'(cyc - lastDone), 32'd10);
                lastDone = cyc;
                k++;
                if (k < 288) begin
                    va   = vals[k / 24];
                    vb   = vals[(k / 2) % 12];
                    vbin = k % 2;
                    a8   = 8'(va);
                    b8   = 8'(vb);
                    bin8 = 1'(vbin);
                end
            end
        end
        start8 = 1'b0;
        checkOutput("sweep_count8", 32'(k), 32'd288);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
